quokka_reset_sequencer: RTL
===========================

Name: quokka_reset_sequencer

Overview:
Central reset/start-up controller for a Quokka board design. It collects reset sources: power-on/async Reset, an external button, a watchdog and soft-reset requesters. It holds the design in reset for a programmable time, then releases reset domains one stage at a time. It generates the Running/Starting/Started board status and replaces ad-hoc InternalReset wiring with one sequenced source.

Parameters:
HOLD_CYCLES, 16, clocks all stages stay in reset after the last reset event (>=2)
STAGES, 3, number of staged reset domains (1..8)
STAGE_GAP, 4, clocks between successive stage releases (>=1)
SYNC_DEPTH, 2, flops in the ExtResetIn synchronizer (>=2)
REQUESTERS, 2, number of soft-reset request inputs
WDT_WIDTH, 16, watchdog counter width

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high master reset
ExtResetIn  in  1  asynchronous external reset button, active-high
SoftResetReq  in  REQUESTERS  synchronous soft-reset requests, any bit high = request
WatchdogEnable  in  1  enables the watchdog while in RUN
WatchdogKick  in  1  clears the watchdog counter
StageReset  out  STAGES  per-domain reset, active-high; bit 0 is released first
InternalReset  out  1  OR of StageReset
Running  out  1  set in STARTING and RUN
Starting  out  1  single-cycle pulse on the first cycle of STARTING
Started  out  1  high in RUN
ResetCause  out  2  cause of the last reset: 00 POR, 01 external, 10 watchdog, 11 soft
Busy  out  1  high in any state other than RUN

Behaviour:
- Clock and reset: one clock, Clock. Reset is asynchronous and active-high. All flops reset asynchronously on Reset.
- Values while Reset is high: state ASSERT, hold counter = HOLD_CYCLES-1, StageReset all 1, InternalReset 1, Running/Starting/Started 0, ResetCause 00, Busy 1, watchdog counter 0, sync chain 0.
- External input: ExtResetIn passes through a SYNC_DEPTH flop chain. extEvt is the chain output.
- Watchdog: counts only in RUN with WatchdogEnable=1. It clears on WatchdogKick or on leaving RUN. wdtEvt fires when the counter is all-ones and no kick is present.
- Soft request: softEvt = |SoftResetReq.
- Event priority when several are present in the same cycle: ext > wdt > soft. ResetCause latches the winning source.
- ASSERT:
  - Hold counter decrements each clock.
  - Any event reloads it to HOLD_CYCLES-1 and updates ResetCause.
  - At counter==0 with no event: go to RELEASE, clear StageReset[0], load gap counter with STAGE_GAP-1, stage index = 1.
- RELEASE:
  - Gap counter decrements each clock.
  - At 0: clear StageReset[index], increment index, reload gap counter.
  - Releasing the last stage moves the FSM to STARTING on the same edge.
  - If STAGES==1, ASSERT goes directly to STARTING.
- STARTING: lasts one cycle with Starting=1 and Running=1, then moves to RUN.
- RUN: Running=1, Started=1, Busy=0.
- Event in RELEASE, STARTING or RUN: on the next edge, go to ASSERT, set all StageReset bits, reload the hold counter, latch ResetCause. Running, Starting and Started drop on that same edge.
- An event wins over a release or a transition scheduled on the same edge.
- Reset mid-operation: asynchronous return to the reset values, with ResetCause=00.
- All outputs are registered except InternalReset, which is an OR of registered bits.

Decomposition:
- Shared package quokka_reset_pkg:
  - state enum: ASSERT, RELEASE, STARTING, RUN
  - ResetCause encodings: CAUSE_POR, CAUSE_EXT, CAUSE_WDT, CAUSE_SOFT
- One sub-module, quokka_sync_chain: parameterised-depth synchronizer with asynchronous Reset, used for ExtResetIn.

Test Plan:
- Defaults; deassert Reset; edge 1 = first rising edge with Reset low -> StageReset=111 through edge 15; 110 at edge 16; 100 at edge 20; 000 at edge 24 with Starting=1 and Running=1; edge 25: Starting=0, Started=1, Busy=0, ResetCause=00.
- In RUN, pulse SoftResetReq=2'b10 for 1 cycle -> next edge: StageReset=111, Started=0, ResetCause=11; stage releases repeat with the same 16/20/24 spacing measured from that edge.
- In RUN, hold ExtResetIn high for 1 cycle -> ASSERT entered 3 edges after the pulse (2 sync + 1 FSM), ResetCause=01; ext and soft in the same cycle -> ResetCause=01.
- WDT_WIDTH=4, WatchdogEnable=1, no kick -> reset 16 clocks after entering RUN, ResetCause=10; kicking every 10 cycles keeps Started=1 for 200 cycles.
- Soft request held continuously during ASSERT -> StageReset stays 111 indefinitely; release at edge 16 after the request drops.
- Assert Reset asynchronously mid-RELEASE (StageReset=100) -> outputs go to 111 / Running=0 / ResetCause=00 without waiting for a clock edge.

Source files
------------

// File: rtl/quokka_reset_pkg.sv
// -----------------------------------------------------------------------------
// quokka_reset_pkg
//
// Shared types for the Quokka reset sequencer.
//   seqState_t    : sequencer FSM states (ASSERT -> RELEASE -> STARTING -> RUN)
//   resetCause_t  : encoding of the ResetCause status output
//   cntWidth()    : width needed to hold a counter value 0..maxValue (min 1)
// -----------------------------------------------------------------------------
package quokka_reset_pkg;

  typedef enum logic [1:0] {
    ASSERT   = 2'd0,  // all domains held in reset, hold counter running
    RELEASE  = 2'd1,  // domains released one at a time
    STARTING = 2'd2,  // single start-up cycle after the last release
    RUN      = 2'd3   // normal operation, watchdog armed
  } seqState_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_EXT  = 2'b01,
    CAUSE_WDT  = 2'b10,
    CAUSE_SOFT = 2'b11
  } resetCause_t;

  function automatic int cntWidth(input int maxValue);
    return (maxValue < 2) ? 1 : $clog2(maxValue + 1);
  endfunction

endpackage

// File: rtl/quokka_sync_chain.sv
// -----------------------------------------------------------------------------
// quokka_sync_chain
//
// DEPTH-flop synchronizer for a single asynchronous level input.
//   Clock    in   sampling clock
//   Reset    in   asynchronous active-high reset, clears the chain
//   AsyncIn  in   asynchronous input
//   SyncOut  out  input delayed by DEPTH clocks, safe to use in Clock domain
// -----------------------------------------------------------------------------
module quokka_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic AsyncIn,
  output logic SyncOut
);

  logic [DEPTH-1:0] chain;

  // NOTE: flops use non-blocking assignments so every stage samples the value
  // its neighbour held before the edge; blocking here would collapse the chain.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], AsyncIn};
    end
  end

  assign SyncOut = chain[DEPTH-1];

endmodule

// File: rtl/quokka_reset_sequencer.sv
// -----------------------------------------------------------------------------
// quokka_reset_sequencer
//
// Central reset / start-up controller. Collects reset events (synchronized
// external button, watchdog, soft requests), holds every domain in reset for
// HOLD_CYCLES after the last event, then releases the StageReset domains one
// at a time, STAGE_GAP clocks apart, bit 0 first. After the last release the
// board goes through one STARTING cycle and then RUN.
//
// Ports:
//   Clock           in   system clock
//   Reset           in   asynchronous active-high master reset (power-on)
//   ExtResetIn      in   asynchronous external reset button, active-high
//   SoftResetReq    in   [REQUESTERS] synchronous soft reset requests
//   WatchdogEnable  in   lets the watchdog count while in RUN
//   WatchdogKick    in   clears the watchdog counter
//   StageReset      out  [STAGES] per-domain reset, active-high
//   InternalReset   out  OR of StageReset
//   Running         out  high in STARTING and RUN
//   Starting        out  one-cycle pulse on the STARTING cycle
//   Started         out  high in RUN
//   ResetCause      out  [2] source of the last reset (see resetCause_t)
//   Busy            out  high whenever not in RUN
// -----------------------------------------------------------------------------
module quokka_reset_sequencer
  import quokka_reset_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 4,
  parameter int SYNC_DEPTH  = 2,
  parameter int REQUESTERS  = 2,
  parameter int WDT_WIDTH   = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ExtResetIn,
  input  logic [REQUESTERS-1:0] SoftResetReq,
  input  logic                  WatchdogEnable,
  input  logic                  WatchdogKick,
  output logic [STAGES-1:0]     StageReset,
  output logic                  InternalReset,
  output logic                  Running,
  output logic                  Starting,
  output logic                  Started,
  output logic [1:0]            ResetCause,
  output logic                  Busy
);

  localparam int HOLD_W = cntWidth(HOLD_CYCLES - 1);
  localparam int GAP_W  = cntWidth(STAGE_GAP - 1);
  localparam int IDX_W  = cntWidth(STAGES - 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(STAGES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  seqState_t            state, stateNext;
  logic [HOLD_W-1:0]    holdCnt, holdCntNext;
  logic [GAP_W-1:0]     gapCnt, gapCntNext;
  logic [IDX_W-1:0]     stageIdx, stageIdxNext;
  logic [STAGES-1:0]    stageRst, stageRstNext;
  resetCause_t          cause, causeNext;
  logic [WDT_WIDTH-1:0] wdtCnt;

  logic runningQ, startingQ, startedQ, busyQ;
  logic runningNext, startingNext, startedNext, busyNext;

  // ---------------------------------------------------------------------------
  // Reset events
  // ---------------------------------------------------------------------------
  logic        extEvt, wdtEvt, softEvt, anyEvt;
  resetCause_t evtCause;

  quokka_sync_chain #(
    .DEPTH (SYNC_DEPTH)
  ) u_extSync (
    .Clock   (Clock),
    .Reset   (Reset),
    .AsyncIn (ExtResetIn),
    .SyncOut (extEvt)
  );

  // A kick in the same cycle as terminal count rescues the board.
  assign wdtEvt  = (state == RUN) && (&wdtCnt) && !WatchdogKick;
  assign softEvt = |SoftResetReq;
  assign anyEvt  = extEvt || wdtEvt || softEvt;

  // Priority when several sources fire together: ext > wdt > soft.
  always_comb begin
    evtCause = CAUSE_SOFT;
    if (extEvt) begin
      evtCause = CAUSE_EXT;
    end else if (wdtEvt) begin
      evtCause = CAUSE_WDT;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: counts only while staying in RUN with the enable set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wdtCnt <= '0;
    end else if (state != RUN || stateNext != RUN || WatchdogKick) begin
      wdtCnt <= '0;
    end else if (WatchdogEnable) begin
      wdtCnt <= wdtCnt + WDT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state register (plus registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ASSERT;
      holdCnt   <= HOLD_LOAD;
      gapCnt    <= GAP_LOAD;
      stageIdx  <= '0;
      stageRst  <= '1;
      cause     <= CAUSE_POR;
      runningQ  <= 1'b0;
      startingQ <= 1'b0;
      startedQ  <= 1'b0;
      busyQ     <= 1'b1;
    end else begin
      state     <= stateNext;
      holdCnt   <= holdCntNext;
      gapCnt    <= gapCntNext;
      stageIdx  <= stageIdxNext;
      stageRst  <= stageRstNext;
      cause     <= causeNext;
      runningQ  <= runningNext;
      startingQ <= startingNext;
      startedQ  <= startedNext;
      busyQ     <= busyNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic. Any event overrides whatever release or
  // transition would otherwise happen on this edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold-value default before the branches, so no
    // path leaves one unassigned and no latch is inferred.
    stateNext    = state;
    holdCntNext  = holdCnt;
    gapCntNext   = gapCnt;
    stageIdxNext = stageIdx;
    stageRstNext = stageRst;
    causeNext    = cause;

    if (anyEvt) begin
      stateNext    = ASSERT;
      holdCntNext  = HOLD_LOAD;
      stageRstNext = '1;
      causeNext    = evtCause;
    end else begin
      unique case (state)
        ASSERT: begin
          if (holdCnt == '0) begin
            stageRstNext[0] = 1'b0;
            gapCntNext      = GAP_LOAD;
            stageIdxNext    = IDX_W'(1);
            stateNext       = (STAGES == 1) ? STARTING : RELEASE;
          end else begin
            holdCntNext = holdCnt - HOLD_W'(1);
          end
        end

        RELEASE: begin
          if (gapCnt == '0) begin
            stageRstNext[stageIdx] = 1'b0;
            stageIdxNext           = stageIdx + IDX_W'(1);
            gapCntNext             = GAP_LOAD;
            if (stageIdx == LAST_IDX) begin
              stateNext = STARTING;
            end
          end else begin
            gapCntNext = gapCnt - GAP_W'(1);
          end
        end

        STARTING: stateNext = RUN;

        RUN: stateNext = RUN;

        default: stateNext = ASSERT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output decode from the next state, registered above so the
  // status outputs change on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    runningNext  = (stateNext == STARTING) || (stateNext == RUN);
    startingNext = (stateNext == STARTING);
    startedNext  = (stateNext == RUN);
    busyNext     = (stateNext != RUN);
  end

  assign StageReset    = stageRst;
  assign InternalReset = |stageRst;
  assign Running       = runningQ;
  assign Starting      = startingQ;
  assign Started       = startedQ;
  assign ResetCause    = cause;
  assign Busy          = busyQ;

endmodule
